// File: rtl/min_vec_feeder.sv
// Packs NUM serial score words into a FindMin request, holds start until done or timeout,
// then presents the minimum (or a timeout error) on a valid/ready output; 1-cycle hops each way.
module min_vec_feeder #(
  parameter int DATA_W  = 16,
  parameter int NUM     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [NUM*DATA_W-1:0] numbers,
  output logic                  start,
  input  logic                  done,
  input  logic [DATA_W-1:0]     result,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err,
  input  logic                  out_ready
);

  localparam int CNT_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_REQ, S_OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept, last_accept, got_done, timed_out, out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    got_done    = 1'b0;
    timed_out   = 1'b0;
    out_fire    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready    = 1'b1;
        accept      = in_valid;
        last_accept = in_valid && (count == LAST_SLOT);
        if (last_accept) state_nxt = S_REQ;
      end
      S_REQ: begin
        // A done arriving on the timeout cycle still wins.
        if (done) begin
          got_done  = 1'b1;
          state_nxt = S_OUT;
        end else if (wait_cnt == WAIT_LIM) begin
          timed_out = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_fire = out_valid && out_ready;
        if (out_fire) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      numbers <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM; k++) begin
        if (count == CNT_W'(k)) numbers[k*DATA_W +: DATA_W] <= in_data;
      end
      count <= last_accept ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
    end else if (last_accept) begin
      start <= 1'b1;
    end else if (got_done || timed_out) begin
      start <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_REQ) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (out_fire) begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (got_done) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_err   <= 1'b0;
    end else if (timed_out) begin
      out_valid <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_min_vec_feeder.sv
// Directed plus randomized bench for min_vec_feeder; inputs driven and outputs sampled on negedge.
module tb_min_vec_feeder;

  localparam int DATA_W  = 16;
  localparam int NUM     = 8;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic [NUM*DATA_W-1:0] numbers;
  logic                  start;
  logic                  done;
  logic [DATA_W-1:0]     result;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_err;
  logic                  out_ready;

  min_vec_feeder #(.DATA_W(DATA_W), .NUM(NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .numbers(numbers), .start(start), .done(done), .result(result),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: what numbers must hold, and the expected pending output.
  logic [NUM*DATA_W-1:0] model_num;
  logic [DATA_W-1:0]     vec [NUM];
  logic [DATA_W-1:0]     exp_dat;
  logic                  exp_err;
  logic                  tied;

  // Shortest run of start-low cycles seen between two requests.
  int  low_run  = 0;
  int  min_gap  = 1000;
  bit  seen_high = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_high = 1'b0;
      low_run   = 0;
    end else if (start) begin
      if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
      seen_high = 1'b1;
      low_run   = 0;
    end else begin
      low_run++;
    end
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [NUM*DATA_W-1:0] obs, input logic [NUM*DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk_b({tag, "_start"}, start, 1'b0);
    chk_b({tag, "_in_ready"}, in_ready, 1'b1);
    chk_b({tag, "_out_valid"}, out_valid, 1'b0);
    chk_d({tag, "_out_data"}, out_data, '0);
    chk_b({tag, "_out_err"}, out_err, 1'b0);
    chk_w({tag, "_numbers"}, numbers, '0);
  endtask

  // gaps: 0 back-to-back, 1 two idle cycles between words, 2 random idles.
  task automatic load_vec(input int gaps);
    int g;
    for (int k = 0; k < NUM; k++) begin
      g = (k == 0) ? 0 : (gaps == 1) ? 2 : (gaps == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        done     = 1'($urandom);
        chk_b("bubble_start", start, 1'b0);
        chk_w("bubble_numbers", numbers, model_num);
        @(negedge clk);
      end
      chk_b("load_start", start, 1'b0);
      chk_b("load_in_ready", in_ready, 1'b1);
      chk_b("load_out_valid", out_valid, 1'b0);
      chk_w("load_numbers", numbers, model_num);
      in_valid = 1'b1;
      in_data  = vec[k];
      done     = 1'($urandom);
      model_num[k*DATA_W +: DATA_W] = vec[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    done     = 1'b0;
    chk_b("start_after_last", start, 1'b1);
    chk_b("req_in_ready", in_ready, 1'b0);
    chk_w("req_numbers", numbers, model_num);
  endtask

  // Responder raises done while start has been high for d cycles; d > TIMEOUT means never.
  task automatic request(input int d, input logic [DATA_W-1:0] res);
    int n;
    exp_err = (d > TIMEOUT);
    exp_dat = exp_err ? '0 : res;
    n = 0;
    while (start === 1'b1 && n < 4 * TIMEOUT) begin
      n++;
      chk_b("req_hold_in_ready", in_ready, 1'b0);
      chk_b("req_out_valid", out_valid, 1'b0);
      done   = (n == d);
      result = (n == d) ? res : DATA_W'($urandom);
      @(negedge clk);
    end
    done = 1'b0;
    chk_w("req_numbers_held", numbers, model_num);
    chk_i("start_high_cycles", n, exp_err ? TIMEOUT : d);
    chk_b("resp_start_low", start, 1'b0);
  endtask

  task automatic drain(input int bp);
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      done      = 1'($urandom);
      chk_b("bp_out_valid", out_valid, 1'b1);
      chk_d("bp_out_data", out_data, exp_dat);
      chk_b("bp_out_err", out_err, exp_err);
      chk_b("bp_in_ready", in_ready, 1'b0);
      chk_b("bp_start", start, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    done      = 1'b0;
    chk_b("out_valid", out_valid, 1'b1);
    chk_d("out_data", out_data, exp_dat);
    chk_b("out_err", out_err, exp_err);
    @(negedge clk);
    out_ready = tied;
    chk_b("post_hs_out_valid", out_valid, 1'b0);
    chk_b("post_hs_in_ready", in_ready, 1'b1);
    chk_b("post_hs_start", start, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] basic [NUM];
    basic = '{16'h0005, 16'h0003, 16'h0009, 16'h0001, 16'h0007, 16'h0002, 16'h0008, 16'h0004};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0; result = '0;
    out_ready = 1'b0; tied = 1'b0; model_num = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Basic request with a fixed vector.
    vec = basic;
    load_vec(0);
    chk_w("basic_numbers", numbers, 128'h0004_0008_0002_0007_0001_0009_0003_0005);
    request(3, 16'h0001);
    drain(0);

    // Bubbled input and output backpressure.
    for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
    load_vec(1);
    request(5, DATA_W'($urandom));
    drain(5);

    // Timeout, then done landing exactly on the timeout cycle, then done on the first cycle.
    for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
    load_vec(0);
    request(1000, 16'hBEEF);
    chk_d("timeout_data", out_data, 16'h0000);
    chk_b("timeout_err", out_err, 1'b1);
    drain(2);
    load_vec(2);
    request(TIMEOUT, 16'h1234);
    drain(0);
    load_vec(0);
    request(1, 16'h8000);
    drain(1);

    // Reset while a vector is half loaded: count must restart at slot 0.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    model_num = '0;

    // Reset in the middle of a request.
    for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
    load_vec(0);
    repeat (3) @(negedge clk);
    chk_b("pre_rst_start", start, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_req");
    @(negedge clk);
    rst_n = 1'b1;
    model_num = '0;
    for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
    load_vec(0);
    request(2, 16'hFFF0);
    chk_d("rst_recover_data", out_data, 16'hFFF0);
    drain(0);

    // Back-to-back requests with out_ready tied high.
    tied = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
      load_vec(0);
      request(2, (r == 0) ? 16'h0002 : 16'h0007);
      chk_d("b2b_data", out_data, (r == 0) ? 16'h0002 : 16'h0007);
      drain(0);
    end
    tied = 1'b0;
    out_ready = 1'b0;

    // Randomized requests.
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < NUM; k++) vec[k] = DATA_W'($urandom);
      load_vec(int'($urandom_range(0, 2)));
      request(int'($urandom_range(1, TIMEOUT + 3)), DATA_W'($urandom));
      drain(int'($urandom_range(0, 3)));
    end

    chk_b("min_start_low_gap", min_gap >= NUM + 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/min_vec_feeder.md
Name: min_vec_feeder

Overview:
Initiator side of the FindMin request interface. Accepts a serial stream of DATA_W-bit scores over a valid/ready input and packs NUM of them into the flat numbers bus. It then raises start and holds it until the min unit returns done, and presents the captured minimum on a valid/ready output. It sits between the score SRAM read path and FindMin in the attention datapath, and adds a timeout so a hung responder cannot stall the pipeline.

Parameters:
DATA_W, 16, width of one score word and of result.
NUM, 8, words per request vector; numbers is NUM*DATA_W bits wide.
TIMEOUT, 255, maximum cycles spent in S_REQ waiting for done (must be at least 2).

Ports:
clk  in  1  clock, all state updates on posedge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream word valid.
in_data  in  DATA_W  upstream score word.
in_ready  out  1  feeder can accept a word.
numbers  out  NUM*DATA_W  packed vector to FindMin; word k at [k*DATA_W +: DATA_W].
start  out  1  request to FindMin; FindMin treats start low as clear.
done  in  1  FindMin finished; result is valid in the same cycle.
result  in  DATA_W  minimum from FindMin.
out_valid  out  1  captured minimum available.
out_data  out  DATA_W  captured minimum, or 0 on timeout.
out_err  out  1  qualifies out_data; 1 means timeout, no valid result.
out_ready  in  1  downstream accepts the output.

Behaviour:
- Reset values: state=S_LOAD, word count=0, numbers=0, start=0, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_err=0, wait counter=0.
- States:
  - S_LOAD:
    - in_ready=1.
    - On each in_valid&&in_ready, in_data is written to slot count and count increments. The first accepted word goes to slot 0.
    - Cycles with in_valid low do not change anything.
    - On accepting the NUM-th word: count returns to 0, state becomes S_REQ, and start is registered to 1. Start is therefore high in the cycle after the last accept.
  - S_REQ:
    - start=1, in_ready=0; numbers is held stable.
    - The wait counter increments every cycle.
    - If done=1 at a posedge: out_data<=result, out_err<=0, out_valid<=1, start<=0, state<=S_OUT.
    - Otherwise, if the wait counter reaches TIMEOUT-1: out_data<=0, out_err<=1, out_valid<=1, start<=0, state<=S_OUT.
    - done takes priority over timeout when both occur in the same cycle.
  - S_OUT:
    - start=0, in_ready=0; out_valid, out_data and out_err are held.
    - On out_valid&&out_ready: out_valid<=0, wait counter<=0, state<=S_LOAD.
- Latency:
  - Last input accept to start high: 1 cycle.
  - done to out_valid: 1 cycle.
  - out_ready handshake to in_ready high: 1 cycle.
- done is ignored in S_LOAD and S_OUT.
- Between requests, start stays low for at least NUM+1 cycles.
- numbers is never cleared except by reset. Old slots are overwritten word by word during the next S_LOAD.
- Reset mid-operation (any state): all registers return to reset values immediately and asynchronously. A partially loaded vector is discarded and start drops at once.
- No arithmetic is done on the data; words pass through unmodified, and sign interpretation belongs to FindMin.

Test Plan:
1. Basic request.
   - Stimulus: load 0005,0003,0009,0001,0007,0002,0008,0004 back-to-back; responder asserts done 3 cycles after start with result 0001.
   - Required: numbers=128'h0004_0008_0002_0007_0001_0009_0003_0005; start rises the cycle after the 8th accept; out_valid=1, out_data=0001, out_err=0; start=0 on the following cycle.
2. Input bubbles.
   - Stimulus: in_valid toggles 1,0,0,1,... while loading 8 words.
   - Required: count advances only on handshakes; start stays 0 until exactly 8 accepts; slot order is unchanged.
3. Output backpressure.
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises.
   - Required: out_valid and out_data held stable; in_ready=0 and start=0 throughout; in_ready=1 one cycle after out_ready rises.
4. Timeout.
   - Stimulus: TIMEOUT=16; responder never asserts done.
   - Required: start is high for exactly 16 cycles; then out_valid=1, out_err=1, out_data=0000, start=0.
5. Reset mid-operation.
   - Stimulus: pulse rst_n low during S_REQ; after release, load 8 new words and return done with result FFF0.
   - Required: start drops immediately on reset; out_data=FFF0; no stale output appears.
6. Back-to-back requests.
   - Stimulus: out_ready tied to 1; send 16 words; return results 0002 then 0007.
   - Required: out_data is 0002 then 0007; start is low for at least 9 cycles between the two requests.
